// File: rtl/cpu_mem_responder.sv
// ============================================================================
// Module   : cpu_mem_responder
// Brief    : Services decoded CPU bus requests on the SRAM/ExROM port or the
//            PPU/APU/IO register bus, with NES open-bus emulation on timeout.
// Revision : 1.0
// ============================================================================
`default_nettype none

module cpu_mem_responder #(
    parameter int          MEM_WAIT    = 1,
    parameter int          REG_TIMEOUT = 15,
    parameter logic [15:0] ROM_BASE    = 16'h0800,
    parameter logic [15:0] ROM_END     = 16'h27E0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [15:0] i_addr_in,
    input  logic        i_addr_valid,
    input  logic        i_we,
    input  logic [7:0]  i_wdata,
    output logic        o_busy,
    output logic        o_ack,
    output logic [7:0]  o_rdata,
    output logic        o_reg_timeout,
    output logic        o_rom_wr_err,
    output logic        o_mem_en,
    output logic        o_mem_we,
    output logic [15:0] o_mem_addr,
    output logic [7:0]  o_mem_wdata,
    input  logic [7:0]  i_mem_rdata,
    output logic        o_reg_req,
    output logic        o_reg_we,
    output logic [15:0] o_reg_addr,
    output logic [7:0]  o_reg_wdata,
    input  logic [7:0]  i_reg_rdata,
    input  logic        i_reg_ack
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MEM  = 2'd1,
        S_REG  = 2'd2
    } state_t;

    localparam logic [3:0] c_WAIT_LOAD = 4'(MEM_WAIT - 1);
    localparam logic [7:0] c_TO_LAST   = 8'(REG_TIMEOUT - 1);

    state_t      r_state;
    logic [3:0]  r_wait_cnt;
    logic [7:0]  r_to_cnt;
    logic        r_ack;
    logic [7:0]  r_rdata;
    logic        r_reg_timeout;
    logic        r_rom_wr_err;
    logic        r_mem_en;
    logic        r_mem_we;
    logic [15:0] r_mem_addr;
    logic [7:0]  r_mem_wdata;
    logic        r_reg_req;
    logic        r_reg_we;
    logic [15:0] r_reg_addr;
    logic [7:0]  r_reg_wdata;

    logic w_in_rom;
    assign w_in_rom = (i_addr_in >= ROM_BASE) && (i_addr_in < ROM_END);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_wait_cnt    <= '0;
            r_to_cnt      <= '0;
            r_ack         <= 1'b0;
            r_rdata       <= '0;
            r_reg_timeout <= 1'b0;
            r_rom_wr_err  <= 1'b0;
            r_mem_en      <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_reg_req     <= 1'b0;
            r_reg_we      <= 1'b0;
            r_reg_addr    <= '0;
            r_reg_wdata   <= '0;
        end else begin
            r_ack         <= 1'b0;
            r_reg_timeout <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_req) begin
                        if (i_addr_valid && i_we && w_in_rom) begin
                            // ROM writes complete immediately without touching SRAM
                            r_rom_wr_err <= 1'b1;
                            r_rdata      <= i_wdata;
                            r_ack        <= 1'b1;
                        end else if (i_addr_valid) begin
                            r_state     <= S_MEM;
                            r_mem_addr  <= i_addr_in;
                            r_mem_wdata <= i_wdata;
                            r_mem_en    <= 1'b1;
                            r_mem_we    <= i_we;
                            r_wait_cnt  <= c_WAIT_LOAD;
                        end else begin
                            r_state     <= S_REG;
                            r_reg_addr  <= i_addr_in;
                            r_reg_wdata <= i_wdata;
                            r_reg_req   <= 1'b1;
                            r_reg_we    <= i_we;
                            r_to_cnt    <= '0;
                        end
                    end
                end
                S_MEM: begin
                    if (r_wait_cnt == 4'd0) begin
                        r_state  <= S_IDLE;
                        r_mem_en <= 1'b0;
                        r_mem_we <= 1'b0;
                        r_ack    <= 1'b1;
                        r_rdata  <= r_mem_we ? r_mem_wdata : i_mem_rdata;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 4'd1;
                    end
                end
                S_REG: begin
                    // An ack on the boundary cycle takes priority over the timeout
                    if (i_reg_ack) begin
                        r_state   <= S_IDLE;
                        r_reg_req <= 1'b0;
                        r_reg_we  <= 1'b0;
                        r_ack     <= 1'b1;
                        r_rdata   <= r_reg_we ? r_reg_wdata : i_reg_rdata;
                    end else if (r_to_cnt == c_TO_LAST) begin
                        r_state       <= S_IDLE;
                        r_reg_req     <= 1'b0;
                        r_reg_we      <= 1'b0;
                        r_ack         <= 1'b1;
                        r_reg_timeout <= 1'b1;
                    end else begin
                        r_to_cnt <= r_to_cnt + 8'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_busy        = (r_state != S_IDLE);
    assign o_ack         = r_ack;
    assign o_rdata       = r_rdata;
    assign o_reg_timeout = r_reg_timeout;
    assign o_rom_wr_err  = r_rom_wr_err;
    assign o_mem_en      = r_mem_en;
    assign o_mem_we      = r_mem_we;
    assign o_mem_addr    = r_mem_addr;
    assign o_mem_wdata   = r_mem_wdata;
    assign o_reg_req     = r_reg_req;
    assign o_reg_we      = r_reg_we;
    assign o_reg_addr    = r_reg_addr;
    assign o_reg_wdata   = r_reg_wdata;

endmodule

`default_nettype wire

// File: tb/tb_cpu_mem_responder.sv
// ============================================================================
// Module   : tb_cpu_mem_responder
// Brief    : Directed self-checking bench for cpu_mem_responder.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_cpu_mem_responder;

    logic        clk;
    logic        rst;
    logic        i_req;
    logic [15:0] i_addr_in;
    logic        i_addr_valid;
    logic        i_we;
    logic [7:0]  i_wdata;
    logic        o_busy;
    logic        o_ack;
    logic [7:0]  o_rdata;
    logic        o_reg_timeout;
    logic        o_rom_wr_err;
    logic        o_mem_en;
    logic        o_mem_we;
    logic [15:0] o_mem_addr;
    logic [7:0]  o_mem_wdata;
    logic [7:0]  i_mem_rdata;
    logic        o_reg_req;
    logic        o_reg_we;
    logic [15:0] o_reg_addr;
    logic [7:0]  o_reg_wdata;
    logic [7:0]  i_reg_rdata;
    logic        i_reg_ack;

    int n_assert = 0;
    int n_fail   = 0;

    cpu_mem_responder #(
        .MEM_WAIT    (1),
        .REG_TIMEOUT (15),
        .ROM_BASE    (16'h0800),
        .ROM_END     (16'h27E0)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .i_req         (i_req),
        .i_addr_in     (i_addr_in),
        .i_addr_valid  (i_addr_valid),
        .i_we          (i_we),
        .i_wdata       (i_wdata),
        .o_busy        (o_busy),
        .o_ack         (o_ack),
        .o_rdata       (o_rdata),
        .o_reg_timeout (o_reg_timeout),
        .o_rom_wr_err  (o_rom_wr_err),
        .o_mem_en      (o_mem_en),
        .o_mem_we      (o_mem_we),
        .o_mem_addr    (o_mem_addr),
        .o_mem_wdata   (o_mem_wdata),
        .i_mem_rdata   (i_mem_rdata),
        .o_reg_req     (o_reg_req),
        .o_reg_we      (o_reg_we),
        .o_reg_addr    (o_reg_addr),
        .o_reg_wdata   (o_reg_wdata),
        .i_reg_rdata   (i_reg_rdata),
        .i_reg_ack     (i_reg_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [15:0] a, input logic av, input logic w, input logic [7:0] d);
        i_req        = 1'b1;
        i_addr_in    = a;
        i_addr_valid = av;
        i_we         = w;
        i_wdata      = d;
    endtask

    initial begin
        int  req_cycles;
        bit  done;

        rst = 1'b0; i_req = 1'b0; i_addr_in = '0; i_addr_valid = 1'b0;
        i_we = 1'b0; i_wdata = '0; i_mem_rdata = '0; i_reg_rdata = '0; i_reg_ack = 1'b0;
        step(); step();
        chk("rst_busy",    16'(o_busy),       16'h0);
        chk("rst_ack",     16'(o_ack),        16'h0);
        chk("rst_rdata",   16'(o_rdata),      16'h0);
        chk("rst_mem_en",  16'(o_mem_en),     16'h0);
        chk("rst_reg_req", 16'(o_reg_req),    16'h0);
        chk("rst_romerr",  16'(o_rom_wr_err), 16'h0);
        rst = 1'b1;
        step();

        // Memory read, one wait cycle
        issue(16'h0123, 1'b1, 1'b0, 8'h00);
        i_mem_rdata = 8'h5A;
        step();
        i_req = 1'b0;
        chk("mrd_mem_en",  16'(o_mem_en),   16'h1);
        chk("mrd_mem_we",  16'(o_mem_we),   16'h0);
        chk("mrd_addr",    o_mem_addr,      16'h0123);
        chk("mrd_busy",    16'(o_busy),     16'h1);
        chk("mrd_noack",   16'(o_ack),      16'h0);
        step();
        chk("mrd_ack",     16'(o_ack),      16'h1);
        chk("mrd_en_off",  16'(o_mem_en),   16'h0);
        chk("mrd_busy0",   16'(o_busy),     16'h0);
        chk("mrd_rdata",   16'(o_rdata),    16'h005A);

        // Write to ROM window base is rejected
        step();
        issue(16'h0800, 1'b1, 1'b1, 8'h33);
        step();
        chk("rom_no_en",   16'(o_mem_en),     16'h0);
        chk("rom_ack",     16'(o_ack),        16'h1);
        chk("rom_err",     16'(o_rom_wr_err), 16'h1);
        chk("rom_rdata",   16'(o_rdata),      16'h0033);
        chk("rom_busy",    16'(o_busy),       16'h0);

        // Write at ROM_END is outside the window; issued in the ack cycle
        issue(16'h27E0, 1'b1, 1'b1, 8'h44);
        step();
        chk("end_mem_en",  16'(o_mem_en),     16'h1);
        chk("end_mem_we",  16'(o_mem_we),     16'h1);
        chk("end_addr",    o_mem_addr,        16'h27E0);
        chk("end_wdata",   16'(o_mem_wdata),  16'h0044);
        chk("end_err",     16'(o_rom_wr_err), 16'h1);
        issue(16'h0200, 1'b1, 1'b0, 8'h44);   // ignored: arrives while busy
        step();
        i_req = 1'b0;
        chk("end_ack",     16'(o_ack),        16'h1);
        chk("end_rdata",   16'(o_rdata),      16'h0044);
        step();
        chk("busy_req_en", 16'(o_mem_en),     16'h0);
        chk("busy_req_ak", 16'(o_ack),        16'h0);

        // Register read acknowledged on the third cycle
        issue(16'h2002, 1'b0, 1'b0, 8'h00);
        step();
        i_req = 1'b0;
        chk("rrd_req",     16'(o_reg_req),  16'h1);
        chk("rrd_addr",    o_reg_addr,      16'h2002);
        chk("rrd_we",      16'(o_reg_we),   16'h0);
        issue(16'h0100, 1'b1, 1'b0, 8'h00);   // ignored: arrives while busy
        step();
        i_req = 1'b0;
        chk("rrd_req_c2",  16'(o_reg_req),  16'h1);
        step();
        chk("rrd_req_c3",  16'(o_reg_req),  16'h1);
        chk("rrd_no_mem",  16'(o_mem_en),   16'h0);
        i_reg_ack = 1'b1; i_reg_rdata = 8'h80;
        step();
        i_reg_ack = 1'b0;
        chk("rrd_req_off", 16'(o_reg_req),     16'h0);
        chk("rrd_ack",     16'(o_ack),         16'h1);
        chk("rrd_rdata",   16'(o_rdata),       16'h0080);
        chk("rrd_to",      16'(o_reg_timeout), 16'h0);
        chk("rrd_busy",    16'(o_busy),        16'h0);

        // Register read with no ack times out; accepted in the ack cycle
        issue(16'h4016, 1'b0, 1'b0, 8'h00);
        i_reg_rdata = 8'hEE;
        step();
        i_req = 1'b0;
        chk("to_req",      16'(o_reg_req), 16'h1);
        chk("to_noack",    16'(o_ack),     16'h0);
        req_cycles = 1;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            step();
            if (o_ack) done = 1'b1;
            else if (o_reg_req) req_cycles++;
        end
        chk("to_seen",     16'(done),          16'h1);
        chk("to_cycles",   16'(req_cycles),    16'd15);
        chk("to_flag",     16'(o_reg_timeout), 16'h1);
        chk("to_req_off",  16'(o_reg_req),     16'h0);
        chk("to_openbus",  16'(o_rdata),       16'h0080);
        step();
        chk("to_flag_end", 16'(o_reg_timeout), 16'h0);
        chk("to_ack_end",  16'(o_ack),         16'h0);

        // reg_ack on the timeout boundary cycle wins
        issue(16'h2007, 1'b0, 1'b0, 8'h00);
        step();
        i_req = 1'b0;
        for (int i = 0; i < 14; i++) step();
        chk("bnd_req",     16'(o_reg_req), 16'h1);
        i_reg_ack = 1'b1; i_reg_rdata = 8'h3C;
        step();
        i_reg_ack = 1'b0;
        chk("bnd_ack",     16'(o_ack),         16'h1);
        chk("bnd_to",      16'(o_reg_timeout), 16'h0);
        chk("bnd_rdata",   16'(o_rdata),       16'h003C);
        step();

        // Reset in the middle of a register access
        issue(16'h2000, 1'b0, 1'b0, 8'h00);
        step();
        i_req = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
        chk("mrst_req",    16'(o_reg_req),    16'h0);
        chk("mrst_busy",   16'(o_busy),       16'h0);
        chk("mrst_ack",    16'(o_ack),        16'h0);
        chk("mrst_rdata",  16'(o_rdata),      16'h0);
        chk("mrst_err",    16'(o_rom_wr_err), 16'h0);
        rst = 1'b1;
        i_reg_ack = 1'b1; i_reg_rdata = 8'h55;
        step();
        i_reg_ack = 1'b0;
        chk("late_ack",    16'(o_ack),   16'h0);
        chk("late_rdata",  16'(o_rdata), 16'h0);
        step();
        chk("late_ack2",   16'(o_ack),   16'h0);
        chk("late_busy",   16'(o_busy),  16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cpu_mem_responder.md
# cpu_mem_responder

Services the decoded CPU bus request. Takes the compacted address and memory/register flag produced by the CPU address decoder and performs the access. Memory-space accesses go to the physical SRAM/ExROM port; register-space accesses go to the PPU/APU/IO register bus. Returns read data with a one-cycle acknowledge and emulates NES open-bus behaviour on register timeouts.

## Interface
- MEM_WAIT, 1: SRAM read latency in cycles (range 1..15); `mem_en` is held for this many cycles.
- REG_TIMEOUT, 15: maximum cycles `reg_req` is held without `reg_ack` (range 1..255; 8-bit counter).
- ROM_BASE, 16'h0800: first decoded address of the ExROM window (inclusive).
- ROM_END, 16'h27E0: end of the ExROM window (exclusive).
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-low.
- req  in  1  request strobe; sampled only while idle.
- addr_in  in  16  decoded address.
- addr_valid  in  1  1 = memory space, 0 = register space.
- we  in  1  1 = write, 0 = read.
- wdata  in  8  write data.
- busy  out  1  high while a transaction is outstanding.
- ack  out  1  one-cycle completion pulse.
- rdata  out  8  read data / open-bus latch.
- reg_timeout  out  1  one-cycle pulse coincident with `ack` when a register access timed out.
- rom_wr_err  out  1  sticky; set by a write into the ExROM window.
- mem_en, mem_we  out  1  SRAM strobe and write enable.
- mem_addr  out  16  SRAM address.
- mem_wdata  out  8  SRAM write data.
- mem_rdata  in  8  SRAM read data.
- reg_req, reg_we  out  1  register-bus request and write enable.
- reg_addr  out  16  register address.
- reg_wdata  out  8  register write data.
- reg_rdata  in  8  register read data.
- reg_ack  in  1  register-bus completion.

## Operation
- States: IDLE, MEM, REG. `busy` = (state != IDLE).
- IDLE with req=1:
  - addr_valid=1, we=1, ROM_BASE <= addr_in < ROM_END: rejected. No `mem_en`. rom_wr_err <= 1, rdata <= wdata, ack next cycle, stay IDLE.
  - Other addr_valid=1: go to MEM. Latch `mem_addr`/`mem_wdata`, set mem_en <= 1, mem_we <= we, load the wait counter.
  - addr_valid=0: go to REG. Latch `reg_addr`/`reg_wdata`, set reg_req <= 1, reg_we <= we, clear the timeout counter.
- MEM:
  - `mem_en` stays high for exactly MEM_WAIT cycles.
  - On the edge ending the last cycle: drop `mem_en`/`mem_we`, pulse `ack`, return to IDLE.
  - rdata <= mem_rdata on reads; rdata <= wdata on writes.
- REG:
  - `reg_req` stays high until `reg_ack` is sampled high. On that edge: drop `reg_req`, pulse `ack`, return to IDLE.
  - rdata <= reg_rdata on reads; rdata <= wdata on writes.
  - If REG_TIMEOUT cycles elapse with `reg_req` high and no `reg_ack`: drop `reg_req`, pulse `ack` and `reg_timeout`, leave `rdata` unchanged (open bus), return to IDLE.
  - `reg_ack` in the same cycle as the timeout boundary wins; no timeout is reported.
- `req` while busy is ignored: no queuing, no side effects.
- `reg_ack` outside REG is ignored.
- `rom_wr_err` clears only on reset.

## Timing
- All outputs are registered. Reset values are 0 for every output.
- Reset asserted mid-transaction: next edge forces IDLE, drops `mem_en`/`reg_req`, and no `ack` is issued.
- Memory access: req sampled at edge E0; `mem_en` high after E0; `ack` high after edge E(MEM_WAIT). Latency is MEM_WAIT+1 cycles.
- ROM-rejected write: `ack` after E1.
- Register access: `ack` in the cycle after `reg_ack` is sampled. On timeout, `reg_req` is high for exactly REG_TIMEOUT cycles.
- State is IDLE during the `ack` cycle, so a `req` presented in the `ack` cycle is accepted.
- Back-to-back memory throughput: one access per MEM_WAIT+1 cycles.

## Test plan
- MEM_WAIT=1, read addr 0x0123 with mem_rdata=0x5A -> `mem_en` high 1 cycle with mem_addr=0x0123, mem_we=0; `ack` 2 cycles after req; rdata=0x5A; busy=0 in the `ack` cycle.
- Write 0x33 to 0x0800, then write 0x44 to 0x27E0 -> first: no `mem_en`, rom_wr_err=1, ack after 1 cycle, rdata=0x33. Second: `mem_en`+`mem_we` with mem_addr=0x27E0, mem_wdata=0x44; rom_wr_err stays 1.
- Register read 0x2002; responder asserts reg_ack after 3 cycles with reg_rdata=0x80 -> `reg_req` high 3 cycles, `ack` next cycle, rdata=0x80, reg_timeout=0.
- Following that, register read 0x4016 with no `reg_ack` (REG_TIMEOUT=15) -> `reg_req` high exactly 15 cycles; `ack` and `reg_timeout` pulse together; rdata remains 0x80.
- New `req` in the `ack` cycle is accepted with no gap; `req` pulses during MEM/REG produce no extra `mem_en`/`reg_req` and no extra `ack`.
- rst=0 during REG at cycle 2 -> `reg_req`=0, busy=0 after next edge; no `ack`; rdata and rom_wr_err = 0; a later `reg_ack` is ignored.
